ps2_key_emitter: RTL and testbench

// Device-side PS/2 keyboard emulator: the transmit end of the link our scan-code decoder receives on.

---
 rtl/ps2_key_emitter.sv | 242 ++++++++++++++++++++++++
 tb/tb_ps2_key_emitter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_emitter.sv
// Device-side PS/2 keyboard emitter: turns a piano key index into set-2 make/break frames on PS2_CLK/PS2_DAT.
// Latency: request accepted in one cycle; first start bit after CLK_HALF idle-clock cycles plus CLK_HALF/2 setup.
// Backpressure: ready is high only in IDLE; key_valid outside IDLE is ignored, host clock inhibit forces a byte retransmit.
module ps2_key_emitter #(
  parameter int CLK_HALF = 2000,
  parameter int BYTE_GAP = 5000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [4:0] key_index,
  input  logic       key_release,
  input  logic       key_valid,
  output logic       ready,
  output logic       key_err,
  output logic       seq_done,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  localparam int CNT_MAX = (CLK_HALF > BYTE_GAP) ? CLK_HALF : BYTE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HALF_END  = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0] SETUP_END = CW'(CLK_HALF / 2 - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(BYTE_GAP - 1);
  localparam logic [CW-1:0] INH_GRACE = CW'(2);
  localparam logic [3:0]    STOP_BIT  = 4'd10;
  localparam logic [7:0]    BREAK_PFX = 8'hF0;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SETUP,
    LOW,
    HIGH,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic [7:0]    code_q, code_d;
  logic          second_q, second_d;
  logic          key_err_q, key_err_d;
  logic          seq_done_q, seq_done_d;
  logic          clk_meta_q, clk_s_q;

  logic [10:0]   frame;
  logic          frame_bit;
  logic          idx_ok;
  logic [7:0]    idx_code;

  // Set-2 make code for each piano key; 0 marks an index outside 1..22.
  always_comb begin
    idx_code = 8'h00;
    case (key_index)
      5'd1:    idx_code = 8'h15;
      5'd2:    idx_code = 8'h1E;
      5'd3:    idx_code = 8'h1D;
      5'd4:    idx_code = 8'h26;
      5'd5:    idx_code = 8'h24;
      5'd6:    idx_code = 8'h25;
      5'd7:    idx_code = 8'h2D;
      5'd8:    idx_code = 8'h2E;
      5'd9:    idx_code = 8'h2C;
      5'd10:   idx_code = 8'h36;
      5'd11:   idx_code = 8'h35;
      5'd12:   idx_code = 8'h3D;
      5'd13:   idx_code = 8'h3C;
      5'd14:   idx_code = 8'h3E;
      5'd15:   idx_code = 8'h43;
      5'd16:   idx_code = 8'h1C;
      5'd17:   idx_code = 8'h1B;
      5'd18:   idx_code = 8'h23;
      5'd19:   idx_code = 8'h2B;
      5'd20:   idx_code = 8'h34;
      5'd21:   idx_code = 8'h33;
      5'd22:   idx_code = 8'h44;
      default: idx_code = 8'h00;
    endcase
  end

  assign idx_ok = (key_index >= 5'd1) && (key_index <= 5'd22);

  // Frame layout, bit 0 first: start 0, data LSB first, odd parity, stop 1.
  always_comb begin
    frame     = {1'b1, ~^byte_q, byte_q, 1'b0};
    frame_bit = frame[bit_q];
  end

  // Two-flop synchroniser on the shared clock line so host inhibit can be seen safely.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_meta_q <= 1'b1;
      clk_s_q    <= 1'b1;
    end else begin
      clk_meta_q <= PS2_CLK;
      clk_s_q    <= clk_meta_q;
    end
  end

  // State, counters and latched byte registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      code_q     <= '0;
      second_q   <= 1'b0;
      key_err_q  <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      code_q     <= code_d;
      second_q   <= second_d;
      key_err_q  <= key_err_d;
      seq_done_q <= seq_done_d;
    end
  end

  // Next-state logic: bit timing, host-inhibit retransmit and multi-byte sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    code_d     = code_q;
    second_d   = second_q;
    key_err_d  = 1'b0;
    seq_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (key_valid) begin
          if (idx_ok) begin
            code_d   = idx_code;
            byte_d   = key_release ? BREAK_PFX : idx_code;
            second_d = key_release;
            state_d  = CHECK;
          end else begin
            key_err_d = 1'b1;
          end
        end
      end

      CHECK: begin
        // Host must leave the clock released for a full half-period before we start.
        if (!clk_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = SETUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SETUP: begin
        if (cnt_q == SETUP_END) begin
          cnt_d   = '0;
          state_d = LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      LOW: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HIGH: begin
        // The first two cycles cover the synchroniser catching up with our own release.
        if ((cnt_q >= INH_GRACE) && !clk_s_q) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = CHECK;
        end else if (cnt_q == HALF_END) begin
          cnt_d = '0;
          if (bit_q == STOP_BIT) begin
            bit_d   = '0;
            state_d = GAP;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = SETUP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d = '0;
          if (second_q) begin
            byte_d   = code_q;
            second_d = 1'b0;
            state_d  = CHECK;
          end else begin
            seq_done_d = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  logic clk_low;
  logic dat_low;

  // Open-drain drivers decoded straight from state so reset releases both lines at once.
  always_comb begin
    clk_low = (state_q == LOW);
    dat_low = ((state_q == SETUP) || (state_q == LOW) || (state_q == HIGH)) && !frame_bit;
  end

  assign PS2_CLK  = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT  = dat_low ? 1'b0 : 1'bz;
  assign ready    = (state_q == IDLE);
  assign key_err  = key_err_q;
  assign seq_done = seq_done_q;

endmodule

// File: tb/tb_ps2_key_emitter.sv
// Bench for ps2_key_emitter: a PS/2 host receiver model decodes frames off the wires
// and checks them against bytes queued from a table-driven model of each key request.
module tb_ps2_key_emitter;

  localparam int CLK_HALF = 12;
  localparam int BYTE_GAP = 30;

  localparam logic [7:0] CODES [22] = '{
    8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h25, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35,
    8'h3D, 8'h3C, 8'h3E, 8'h43, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h44
  };

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] key_index = '0;
  logic       key_release = 1'b0;
  logic       key_valid = 1'b0;
  logic       host_inh = 1'b0;
  wire        ready;
  wire        key_err;
  wire        seq_done;
  wire        ps2_clk;
  wire        ps2_dat;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = host_inh ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ps2_key_emitter #(
    .CLK_HALF(CLK_HALF),
    .BYTE_GAP(BYTE_GAP)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .key_index  (key_index),
    .key_release(key_release),
    .key_valid  (key_valid),
    .ready      (ready),
    .key_err    (key_err),
    .seq_done   (seq_done),
    .PS2_CLK    (ps2_clk),
    .PS2_DAT    (ps2_dat)
  );

  logic [7:0]  exp_q[$];
  int          done_exp = 0;
  int          err_exp = 0;
  int          tests = 0;
  int          fails = 0;
  int          rx_n = 0;
  int          rx_edges = 0;
  int          viol = 0;
  logic [10:0] rx_sh = '0;
  logic        prev_clk = 1'b1;
  logic        prev_dat = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Host receiver and output monitor, sampled on the falling system clock edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!resetn || host_inh) begin
      rx_n = 0;
    end else begin
      if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
        rx_edges++;
        rx_sh[rx_n] = ps2_dat;
        rx_n++;
        if (rx_n == 11) begin
          rx_n = 0;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL frame_unexpected: got frame 0x%0h, expected no frame", rx_sh);
          end else begin
            e = exp_q.pop_front();
            check("start_bit", rx_sh[0], 1'b0);
            check("data_byte", rx_sh[8:1], e);
            check("parity_bit", rx_sh[9], ~^e);
            check("stop_bit", rx_sh[10], 1'b1);
          end
        end
      end
      if (prev_clk === 1'b0 && ps2_clk === 1'b0 && ps2_dat !== prev_dat) viol++;
    end
    prev_clk = ps2_clk;
    prev_dat = ps2_dat;
    if (seq_done === 1'b1) begin
      tests++;
      if (done_exp == 0) begin
        fails++;
        $display("FAIL seq_done_unexpected: got pulse, expected none");
      end else begin
        done_exp--;
      end
      check("bytes_left_at_done", exp_q.size(), 0);
      check("ready_at_done", ready, 1'b1);
    end
    if (key_err === 1'b1) begin
      tests++;
      if (err_exp == 0) begin
        fails++;
        $display("FAIL key_err_unexpected: got pulse, expected none");
      end else begin
        err_exp--;
      end
      check("ready_at_key_err", ready, 1'b1);
    end
  end

  // Issue one request and queue what the host should see.
  task automatic send(input int idx, input bit rel);
    @(negedge clk);
    key_index   = idx[4:0];
    key_release = rel;
    key_valid   = 1'b1;
    if (idx >= 1 && idx <= 22) begin
      if (rel) exp_q.push_back(8'hF0);
      exp_q.push_back(CODES[idx-1]);
      done_exp++;
    end else begin
      err_exp++;
    end
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // A request while busy must be dropped silently.
  task automatic poke(input int idx);
    @(negedge clk);
    key_index = idx[4:0];
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string nm);
    for (int i = 0; i < 3000; i++) begin
      if (done_exp == 0 && err_exp == 0 && exp_q.size() == 0 && ready === 1'b1) break;
      @(negedge clk);
    end
    check(nm, (done_exp == 0 && err_exp == 0 && exp_q.size() == 0 && ready === 1'b1), 1'b1);
  endtask

  task automatic wait_rx(input int n, input string nm);
    for (int i = 0; i < 2000; i++) begin
      if (rx_n == n) break;
      @(negedge clk);
    end
    check(nm, rx_n, n);
  endtask

  initial begin
    int edges0;
    int idx;
    bit rel;

    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_key_err", key_err, 1'b0);
    check("rst_seq_done", seq_done, 1'b0);
    check("rst_clk_line", ps2_clk, 1'b1);
    check("rst_dat_line", ps2_dat, 1'b1);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    send(1, 1'b0);
    check("busy_after_accept", ready, 1'b0);
    wait_quiet("make_idx1_done");

    send(22, 1'b1);
    wait_quiet("release_idx22_done");

    edges0 = rx_edges;
    send(0, 1'b0);
    wait_quiet("err_idx0_done");
    send(23, 1'b0);
    wait_quiet("err_idx23_done");
    repeat (40) @(negedge clk);
    check("err_no_clock_edges", rx_edges, edges0);
    check("err_lines_idle", {ps2_clk, ps2_dat}, 2'b11);

    for (int k = 1; k <= 22; k++) begin
      send(k, 1'b0);
      wait_quiet("make_all_done");
    end

    // Host inhibit during the high phase after bit 5 forces a full-byte resend.
    send(7, 1'b0);
    wait_rx(6, "inh_reach_bit5");
    for (int i = 0; i < 100 && ps2_clk !== 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    host_inh = 1'b1;
    repeat (6) @(negedge clk);
    check("inh_dat_released", ps2_dat, 1'b1);
    check("inh_still_busy", ready, 1'b0);
    repeat (3 * CLK_HALF) @(negedge clk);
    host_inh = 1'b0;
    wait_quiet("inh_resend_done");

    // Reset in the middle of a frame.
    send(5, 1'b1);
    wait_rx(4, "rst_reach_bit3");
    @(posedge clk);
    #1;
    resetn = 1'b0;
    exp_q.delete();
    done_exp = 0;
    #1;
    check("midrst_clk_line", ps2_clk, 1'b1);
    check("midrst_dat_line", ps2_dat, 1'b1);
    check("midrst_ready", ready, 1'b1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    send(3, 1'b0);
    wait_quiet("post_rst_frame_done");

    for (int r = 0; r < 20; r++) begin
      idx = int'($urandom_range(0, 23));
      rel = 1'($urandom_range(0, 1));
      send(idx, rel);
      if (idx >= 1 && idx <= 22 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(5, 60)) @(negedge clk);
        check("busy_ready_low", ready, 1'b0);
        poke(int'($urandom_range(0, 31)));
      end
      wait_quiet("random_done");
    end

    check("data_stable_while_clk_low", viol, 0);
    check("final_bytes_outstanding", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
